// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : Valid/ready pipeline stage with optional two-entry skid buffer,
//            synchronous flush and saturating stall/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 12,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_two   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic              w_accept;
    logic              w_issue;

    assign out_valid  = (r_state != c_st_empty);
    assign out_ctrl   = out_valid ? r_main_ctrl : '0;
    assign out_data   = r_main_data;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign w_accept   = in_valid && in_ready;
    assign w_issue    = out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_empty: if (w_accept) w_state_next = c_st_one;
            c_st_one: begin
                if (w_accept && !w_issue)      w_state_next = c_st_two;
                else if (!w_accept && w_issue) w_state_next = c_st_empty;
            end
            c_st_two:   if (w_issue) w_state_next = c_st_one;
            default:    w_state_next = c_st_empty;
        endcase
        // Flush overrides any accept or issue in the same cycle.
        if (flush) w_state_next = c_st_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_empty;
            r_main_ctrl <= '0;
            r_main_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (flush) begin
                r_main_ctrl <= '0;
            end else if (r_state == c_st_two) begin
                if (w_issue) begin
                    r_main_ctrl <= w_skid_ctrl;
                    r_main_data <= w_skid_data;
                end
            end else if (w_accept && (r_state == c_st_empty || w_issue)) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;
            logic              r_in_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                    r_in_ready  <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_next != c_st_two);
                    if (flush) begin
                        r_skid_ctrl <= '0;
                    end else if (r_state == c_st_one && w_accept && !w_issue) begin
                        r_skid_ctrl <= in_ctrl;
                        r_skid_data <= in_data;
                    end
                end
            end

            assign w_skid_ctrl = r_skid_ctrl;
            assign w_skid_data = r_skid_data;
            assign in_ready    = r_in_ready;
        end else begin : g_no_skid
            // Single entry: a slot frees up in the same cycle the head issues.
            assign w_skid_ctrl = '0;
            assign w_skid_data = '0;
            assign in_ready    = !out_valid || out_ready;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (!out_valid && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Brief    : Directed self-checking bench for pipe_stage_skid (skid, no-skid
//            and 4-bit counter variants).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // SKID=1, CNT_W=16
    logic        s1_rst = 1'b1, s1_flush = 1'b0, s1_in_valid = 1'b0, s1_out_ready = 1'b0;
    logic [11:0] s1_in_ctrl = '0;
    logic [15:0] s1_in_data = '0;
    logic        s1_in_ready, s1_out_valid;
    logic [11:0] s1_out_ctrl;
    logic [15:0] s1_out_data, s1_stall, s1_bubble;

    // SKID=0, CNT_W=16
    logic        s0_rst = 1'b1, s0_in_valid = 1'b0, s0_out_ready = 1'b0;
    logic [11:0] s0_in_ctrl = '0;
    logic [15:0] s0_in_data = '0;
    logic        s0_in_ready, s0_out_valid;
    logic [11:0] s0_out_ctrl;
    logic [15:0] s0_out_data, s0_stall, s0_bubble;

    // SKID=1, CNT_W=4
    logic        k4_rst = 1'b1, k4_in_valid = 1'b0, k4_out_ready = 1'b0;
    logic [11:0] k4_in_ctrl = '0;
    logic [15:0] k4_in_data = '0;
    logic        k4_in_ready, k4_out_valid;
    logic [11:0] k4_out_ctrl;
    logic [15:0] k4_out_data;
    logic [3:0]  k4_stall, k4_bubble;

    pipe_stage_skid #(.DATA_W(16), .CTRL_W(12), .SKID(1), .CNT_W(16)) dut_s1 (
        .clk(clk), .rst(s1_rst), .flush(s1_flush),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_ctrl(s1_in_ctrl), .in_data(s1_in_data),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_ctrl(s1_out_ctrl), .out_data(s1_out_data),
        .stall_cnt(s1_stall), .bubble_cnt(s1_bubble)
    );

    pipe_stage_skid #(.DATA_W(16), .CTRL_W(12), .SKID(0), .CNT_W(16)) dut_s0 (
        .clk(clk), .rst(s0_rst), .flush(1'b0),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_ctrl(s0_in_ctrl), .in_data(s0_in_data),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_ctrl(s0_out_ctrl), .out_data(s0_out_data),
        .stall_cnt(s0_stall), .bubble_cnt(s0_bubble)
    );

    pipe_stage_skid #(.DATA_W(16), .CTRL_W(12), .SKID(1), .CNT_W(4)) dut_k4 (
        .clk(clk), .rst(k4_rst), .flush(1'b0),
        .in_valid(k4_in_valid), .in_ready(k4_in_ready), .in_ctrl(k4_in_ctrl), .in_data(k4_in_data),
        .out_valid(k4_out_valid), .out_ready(k4_out_ready), .out_ctrl(k4_out_ctrl), .out_data(k4_out_data),
        .stall_cnt(k4_stall), .bubble_cnt(k4_bubble)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset, two cycles
        step();
        step();
        check_eq("rst_out_valid",  32'(s1_out_valid), 32'd0);
        check_eq("rst_out_ctrl",   32'(s1_out_ctrl),  32'd0);
        check_eq("rst_out_data",   32'(s1_out_data),  32'd0);
        check_eq("rst_in_ready",   32'(s1_in_ready),  32'd1);
        check_eq("rst_stall_cnt",  32'(s1_stall),     32'd0);
        check_eq("rst_bubble_cnt", 32'(s1_bubble),    32'd0);

        // ---- back-to-back streaming, one-cycle latency
        s1_rst       = 1'b0;
        s1_out_ready = 1'b1;
        s1_in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            s1_in_data = 16'(i);
            s1_in_ctrl = 12'(i);
            step();
            check_eq("stream_valid", 32'(s1_out_valid), 32'd1);
            check_eq("stream_data",  32'(s1_out_data),  32'(i));
            check_eq("stream_ctrl",  32'(s1_out_ctrl),  32'(i));
            check_eq("stream_ready", 32'(s1_in_ready),  32'd1);
        end
        s1_in_valid = 1'b0;
        step();
        check_eq("stream_drained", 32'(s1_out_valid), 32'd0);
        check_eq("stream_bubble",  32'(s1_bubble),    32'd1);
        check_eq("stream_stall",   32'(s1_stall),     32'd0);

        // ---- fill skid while stalled, then drain in order
        s1_out_ready = 1'b0;
        s1_in_valid  = 1'b1;
        s1_in_data   = 16'hAAAA;
        s1_in_ctrl   = 12'h00A;
        step();
        check_eq("skid_a_data",  32'(s1_out_data), 32'hAAAA);
        check_eq("skid_a_ready", 32'(s1_in_ready), 32'd1);
        check_eq("skid_bubble",  32'(s1_bubble),   32'd2);
        s1_in_data = 16'hBBBB;
        s1_in_ctrl = 12'h00B;
        step();
        check_eq("skid_b_ready", 32'(s1_in_ready), 32'd0);
        check_eq("skid_b_head",  32'(s1_out_data), 32'hAAAA);
        s1_in_data = 16'hCCCC;
        s1_in_ctrl = 12'h00C;
        step();
        check_eq("skid_full_ready", 32'(s1_in_ready), 32'd0);
        check_eq("skid_full_head",  32'(s1_out_data), 32'hAAAA);
        check_eq("skid_full_stall", 32'(s1_stall),    32'd2);
        step();
        check_eq("skid_hold_stall", 32'(s1_stall), 32'd3);
        s1_out_ready = 1'b1;
        step();
        check_eq("drain_b_data",  32'(s1_out_data), 32'hBBBB);
        check_eq("drain_b_ctrl",  32'(s1_out_ctrl), 32'h00B);
        check_eq("drain_b_ready", 32'(s1_in_ready), 32'd1);
        step();
        check_eq("drain_c_data", 32'(s1_out_data), 32'hCCCC);
        s1_in_valid = 1'b0;
        step();
        check_eq("drain_empty", 32'(s1_out_valid), 32'd0);
        check_eq("drain_stall", 32'(s1_stall),     32'd3);

        // ---- flush from TWO beats accept and issue
        s1_out_ready = 1'b0;
        s1_in_valid  = 1'b1;
        s1_in_data   = 16'h1111;
        s1_in_ctrl   = 12'h111;
        step();
        s1_in_data = 16'h2222;
        s1_in_ctrl = 12'h222;
        step();
        check_eq("pre_flush_ready", 32'(s1_in_ready), 32'd0);
        s1_flush     = 1'b1;
        s1_out_ready = 1'b1;
        s1_in_data   = 16'hEEEE;
        s1_in_ctrl   = 12'hFFF;
        step();
        check_eq("flush_valid", 32'(s1_out_valid), 32'd0);
        check_eq("flush_ctrl",  32'(s1_out_ctrl),  32'd0);
        check_eq("flush_ready", 32'(s1_in_ready),  32'd1);
        check_eq("flush_data",  32'(s1_out_data),  32'h1111);
        check_eq("flush_stall", 32'(s1_stall),     32'd4);
        s1_flush    = 1'b0;
        s1_in_valid = 1'b0;
        step();
        check_eq("flush_no_ghost", 32'(s1_out_valid), 32'd0);
        s1_in_valid = 1'b1;
        s1_in_data  = 16'h3333;
        s1_in_ctrl  = 12'h333;
        step();
        check_eq("post_flush_data", 32'(s1_out_data), 32'h3333);
        check_eq("post_flush_ctrl", 32'(s1_out_ctrl), 32'h333);
        s1_in_valid = 1'b0;
        step();
        check_eq("idle_ctrl_zero", 32'(s1_out_ctrl), 32'd0);

        // ---- 4-bit stall counter saturation
        k4_rst       = 1'b0;
        k4_in_valid  = 1'b1;
        k4_in_data   = 16'h5555;
        k4_in_ctrl   = 12'h555;
        step();
        k4_in_valid = 1'b0;
        check_eq("sat_held", 32'(k4_out_data), 32'h5555);
        for (int i = 0; i < 14; i++) step();
        check_eq("sat_14", 32'(k4_stall), 32'd14);
        for (int i = 0; i < 6; i++) step();
        check_eq("sat_15",    32'(k4_stall),  32'd15);
        check_eq("sat_bub",   32'(k4_bubble), 32'd1);

        // ---- SKID=0 combinational ready, full throughput
        s0_rst       = 1'b0;
        s0_out_ready = 1'b1;
        s0_in_valid  = 1'b1;
        #1;
        check_eq("ns_empty_ready", 32'(s0_in_ready), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            s0_in_data = 16'h6000 + 16'(i);
            step();
            check_eq("ns_data",  32'(s0_out_data), 32'h6000 + 32'(i));
            check_eq("ns_ready", 32'(s0_in_ready), 32'd1);
        end
        s0_out_ready = 1'b0;
        s0_in_data   = 16'h6005;
        #1;
        check_eq("ns_blocked_ready", 32'(s0_in_ready), 32'd0);
        step();
        check_eq("ns_blocked_head", 32'(s0_out_data), 32'h6004);
        check_eq("ns_stall",        32'(s0_stall),    32'd1);
        s0_out_ready = 1'b1;
        step();
        check_eq("ns_resume", 32'(s0_out_data), 32'h6005);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
